// File: rtl/router_output_arbiter.sv
// Round-robin arbiter with a one-entry output register for a single router
// output port. Every input handler (and the local cache path) that targets
// this direction raises req and holds its packet until granted. The winner
// is captured into the output register, which drains toward the downstream
// port under valid/ready handshaking, so packets are never dropped or
// duplicated.
module router_output_arbiter #(
  parameter int NUM_REQ      = 5,
  parameter int PACKET_WIDTH = 40
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] packetIn,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            validOut,
  output logic [PACKET_WIDTH-1:0]         packetOut,
  input  logic                            downstreamReady,
  output logic                            busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic               acc;
  logic               anyGrant;
  logic [PTR_W-1:0]   winIdx;
  logic [PTR_W:0]     sum;
  logic [PTR_W-1:0]   idx;

  // The register can take a new packet when it is free or is draining this cycle.
  assign acc  = (state == EMPTY) || (validOut && downstreamReady);
  assign busy = validOut;

  // Rotating priority search starting at ptr; reset masks all grants.
  always_comb begin
    anyGrant = 1'b0;
    winIdx   = '0;
    sum      = '0;
    idx      = '0;
    if (!reset && acc) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, ptr} + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(NUM_REQ)) begin
          sum = sum - (PTR_W+1)'(NUM_REQ);
        end
        idx = sum[PTR_W-1:0];
        if (!anyGrant && req[idx]) begin
          anyGrant = 1'b1;
          winIdx   = idx;
        end
      end
    end
    grant = anyGrant ? (NUM_REQ'(1) << winIdx) : '0;
  end

  // Output register, state and priority pointer. A grant in the same cycle as
  // a drain overwrites the old packet, giving one packet per cycle throughput.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      validOut  <= 1'b0;
      packetOut <= '0;
      ptr       <= '0;
    end else if (anyGrant) begin
      state     <= FULL;
      validOut  <= 1'b1;
      packetOut <= packetIn[winIdx*PACKET_WIDTH +: PACKET_WIDTH];
      ptr       <= (winIdx == PTR_W'(NUM_REQ-1)) ? '0 : winIdx + 1'b1;
    end else if (validOut && downstreamReady) begin
      state     <= EMPTY;
      validOut  <= 1'b0;
    end
  end

endmodule
